wb_queue_2w: RTL

Two-wide writeback queue between the execution units and the multi-port register cells of the physical register file. Each cycle it accepts up to two completed results (tag plus data) and drains up to two of them, oldest first, onto the register-file write ports. It absorbs bursts when more results finish than the write ports can take, and holds results while the register file is stalled.

---
 rtl/wb_queue_2w.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/wb_queue_2w.sv
// wb_queue_2w: two-wide writeback queue feeding the register-file write ports.
// Accepts up to two results per cycle, compacted at the tail, and drains up to
// two per cycle, oldest first, unless the register file stalls.
// Optional feature macro: WB_BYPASS_EN -- when defined, results arriving at an
// empty, unstalled queue go straight to the write ports in the same cycle.
module wb_queue_2w #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in1_valid_i,
    input  logic [TAG_WIDTH-1:0]         in1_tag_i,
    input  logic [DATA_WIDTH-1:0]        in1_data_i,
    input  logic                         in2_valid_i,
    input  logic [TAG_WIDTH-1:0]         in2_tag_i,
    input  logic [DATA_WIDTH-1:0]        in2_data_i,
    output logic                         in_ready_o,
    input  logic                         wb_stall_i,
    output logic                         wr1_en_o,
    output logic [TAG_WIDTH-1:0]         wr1_tag_o,
    output logic [DATA_WIDTH-1:0]        wr1_data_o,
    output logic                         wr2_en_o,
    output logic [TAG_WIDTH-1:0]         wr2_tag_o,
    output logic [DATA_WIDTH-1:0]        wr2_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    // Storage and pointers
    logic [TAG_WIDTH-1:0]  tag_mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Compacted input slots
    logic                  s0_v, s1_v;
    logic [TAG_WIDTH-1:0]  s0_tag, s1_tag;
    logic [DATA_WIDTH-1:0] s0_data, s1_data;
    logic                  bypass_c;
    logic                  accept_c;
    logic                  we0_c, we1_c;
    logic [1:0]            n_in_c, n_out_c;
    logic [PTR_W-1:0]      head1_c, tail1_c;

    // Compact the two lanes so the oldest valid result always lands in slot 0
    always_comb begin
        s0_v    = in1_valid_i | in2_valid_i;
        s1_v    = in1_valid_i & in2_valid_i;
        s0_tag  = '0;
        s0_data = '0;
        if (in1_valid_i) begin
            s0_tag  = in1_tag_i;
            s0_data = in1_data_i;
        end else if (in2_valid_i) begin
            s0_tag  = in2_tag_i;
            s0_data = in2_data_i;
        end
        s1_tag  = s1_v ? in2_tag_i  : '0;
        s1_data = s1_v ? in2_data_i : '0;
    end

    // Enqueue/dequeue control and next pointer/count state
    always_comb begin
        in_ready_o = (count_q <= CNT_W'(DEPTH-2));
`ifdef WB_BYPASS_EN
        bypass_c   = !rst && (count_q == '0) && !wb_stall_i && in_ready_o;
`else
        bypass_c   = 1'b0;
`endif
        accept_c   = in_ready_o & ~bypass_c;
        we0_c      = s0_v & accept_c;
        we1_c      = s1_v & accept_c;
        n_in_c     = {1'b0, we0_c} + {1'b0, we1_c};

        n_out_c = 2'd0;
        if (!wb_stall_i) begin
            if (count_q >= CNT_W'(2)) n_out_c = 2'd2;
            else                      n_out_c = count_q[1:0];
        end

        head1_c = head_q + PTR_W'(1);
        tail1_c = tail_q + PTR_W'(1);
        head_d  = head_q + PTR_W'(n_out_c);
        tail_d  = tail_q + PTR_W'(n_in_c);
        count_d = count_q + CNT_W'(n_in_c) - CNT_W'(n_out_c);
        count_o = count_q;
    end

    // Write-port drive: head entries when draining, or the inputs when bypassing
    always_comb begin
        wr1_en_o   = 1'b0;
        wr1_tag_o  = '0;
        wr1_data_o = '0;
        wr2_en_o   = 1'b0;
        wr2_tag_o  = '0;
        wr2_data_o = '0;
        if (n_out_c != 2'd0) begin
            wr1_en_o   = 1'b1;
            wr1_tag_o  = tag_mem_q[head_q];
            wr1_data_o = data_mem_q[head_q];
        end
        if (n_out_c == 2'd2) begin
            wr2_en_o   = 1'b1;
            wr2_tag_o  = tag_mem_q[head1_c];
            wr2_data_o = data_mem_q[head1_c];
        end
        if (bypass_c) begin
            wr1_en_o   = s0_v;
            wr1_tag_o  = s0_tag;
            wr1_data_o = s0_data;
            wr2_en_o   = s1_v;
            wr2_tag_o  = s1_tag;
            wr2_data_o = s1_data;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed through valid head entries
    always_ff @(posedge clk) begin
        if (we0_c) begin
            tag_mem_q[tail_q]  <= s0_tag;
            data_mem_q[tail_q] <= s0_data;
        end
        if (we1_c) begin
            tag_mem_q[tail1_c]  <= s1_tag;
            data_mem_q[tail1_c] <= s1_data;
        end
    end

endmodule
